id_decode_latch: RTL and testbench
==================================

Name: id_decode_latch

Overview:
- Decode-side consumer of the IF/ID pipeline register.
- Accepts the registered next-PC and instruction under a valid/ready handshake, and splits the instruction into MIPS fields.
- Sign-extends the immediate and registers everything into the ID/EX boundary.
- Detects load-use hazards against the instruction it currently holds, inserts one NOP bubble, and back-pressures fetch.

Parameters:
- DATA_W, 32, width of npc, instr, npc_out, imm_out
- LW_OPCODE, 6'h23, opcode treated as a load for hazard detection
- CNT_W, 16, width of the saturating bubble counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- in_valid  input  1  npc/instr from IF/ID are valid
- in_ready  output  1  block accepts npc/instr this cycle
- npc  input  DATA_W  next PC from IF/ID
- instr  input  DATA_W  instruction from IF/ID
- flush  input  1  synchronous squash of held and incoming instruction
- out_ready  input  1  ID/EX consumer accepts this cycle
- out_valid  output  1  registered fields are valid
- npc_out  output  DATA_W  registered npc
- opcode_out  output  6  instr[31:26]
- rs_out  output  5  instr[25:21]
- rt_out  output  5  instr[20:16]
- rd_out  output  5  instr[15:11]
- shamt_out  output  5  instr[10:6]
- funct_out  output  6  instr[5:0]
- imm_out  output  DATA_W  sign-extended instr[15:0]
- bubble_cnt  output  CNT_W  count of inserted bubbles, saturating

Behaviour:
- Reset (reset=0, asynchronous): all outputs and registers go to 0, including out_valid, bubble_cnt and the state (EMPTY).
- States:
  - EMPTY: out_valid=0.
  - HOLD: out_valid=1, real instruction held.
  - BUBBLE: out_valid=1, NOP held.
- Output register advance:
  - adv = !out_valid | out_ready.
  - Output register updates only when adv=1; otherwise all outputs hold.
- Hazard condition:
  - hz = out_valid & opcode_out==LW_OPCODE & rt_out!=0 & (rt_out==instr[25:21] | (rt_out==instr[20:16] & instr[31:26] in {6'h00,6'h04,6'h05,6'h2B})).
  - hz is evaluated only in HOLD.
- in_ready = adv & !hz & !flush. This is combinational; it never depends on in_valid.
- Accept (in_valid & in_ready): the next cycle registers npc and the decoded fields; state becomes HOLD. Latency is 1 cycle from accept to out_valid.
- Bubble (in_valid & adv & hz & !flush):
  - next cycle: all fields and npc_out = 0, out_valid=1, state = BUBBLE;
  - bubble_cnt increments, saturating at all-ones;
  - the pending instruction stays at IF/ID and is accepted on a later cycle, since NOP is not a load.
- adv=1 with no accept and no bubble: out_valid=0, state = EMPTY; field values are don't-care but are held.
- Flush: has priority over accept and bubble.
  - next cycle: out_valid=0, state = EMPTY, fields zeroed;
  - the incoming instr is not accepted;
  - bubble_cnt is unchanged.
- Flush and out_ready=0 together: the flush still clears (the squash wins).
- Reset mid-bubble: returns to EMPTY immediately; the pending IF/ID instruction is simply re-presented after reset.
- Sign extension: imm_out = {{(DATA_W-16){instr[15]}}, instr[15:0]}.

Optional Feature:
- Macro: BRANCH_TARGET_EN.
- When defined:
  - adds output branch_target, DATA_W wide;
  - registered with the other fields, value npc + (sign-extended imm << 2), modulo 2^DATA_W (wraps);
  - zero on reset, bubble and flush.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset=0 with in_valid=1, instr=32'h012A4020 -> all outputs 0 and in_ready irrelevant. Release reset -> next cycle out_valid=1, rs=9, rt=10, rd=8, funct=6'h20.
- Accept lw $t0,4($s0) (32'h8E080004), then add $t1,$t0,$t2 (32'h010A4820) with out_ready=1:
  - in_ready=0 for one cycle;
  - next output is NOP with out_valid=1, bubble_cnt=1;
  - the add is accepted on the following cycle.
- lw with rt=0 (32'h8E000004) followed by add using $0 -> no bubble; bubble_cnt stays 0.
- out_ready=0 for 3 cycles while holding instr 32'h2108FFFF:
  - in_ready=0 and outputs stable;
  - imm_out=32'hFFFFFFFF.
- flush=1 while holding lw and presenting a dependent add -> next cycle out_valid=0, add not accepted, bubble_cnt unchanged.
- With BRANCH_TARGET_EN, beq with npc=32'hFFFFFFFC and imm=16'h0002 -> branch_target=32'h00000004 (wrap).

Source files
------------

// File: rtl/id_decode_latch_if.sv
// ---------------------------------------------------------------------------
// id_decode_latch_if
//
// Bundles the IF/ID-side handshake (in_valid/in_ready/npc/instr/flush) and the
// ID/EX-side registered outputs (out_valid/out_ready, decoded fields, bubble
// counter) of id_decode_latch into one interface.
//
// Modports:
//   slave  - the decode latch itself (consumes npc/instr, drives the fields)
//   master - the environment around it (fetch side plus ID/EX consumer)
//
// Optional: when BRANCH_TARGET_EN is defined, a branch_target signal is added.
// Parameters must match the ones given to id_decode_latch.
// ---------------------------------------------------------------------------
interface id_decode_latch_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // IF/ID side
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] instr;
    logic              flush;

    // ID/EX side
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] npc_out;
    logic [5:0]        opcode_out;
    logic [4:0]        rs_out;
    logic [4:0]        rt_out;
    logic [4:0]        rd_out;
    logic [4:0]        shamt_out;
    logic [5:0]        funct_out;
    logic [DATA_W-1:0] imm_out;
    logic [CNT_W-1:0]  bubble_cnt;
`ifdef BRANCH_TARGET_EN
    logic [DATA_W-1:0] branch_target;
`endif

    modport slave (
`ifdef BRANCH_TARGET_EN
        output branch_target,
`endif
        input  in_valid, npc, instr, flush, out_ready,
        output in_ready, out_valid, npc_out, opcode_out, rs_out, rt_out,
               rd_out, shamt_out, funct_out, imm_out, bubble_cnt
    );

    modport master (
`ifdef BRANCH_TARGET_EN
        input  branch_target,
`endif
        output in_valid, npc, instr, flush, out_ready,
        input  in_ready, out_valid, npc_out, opcode_out, rs_out, rt_out,
               rd_out, shamt_out, funct_out, imm_out, bubble_cnt
    );

endinterface

// File: rtl/id_decode_latch.sv
// ---------------------------------------------------------------------------
// id_decode_latch
//
// Decode-side consumer of the IF/ID pipeline register. Accepts npc/instr under
// a valid/ready handshake, splits the instruction into MIPS fields, sign-
// extends the immediate and registers everything into the ID/EX boundary.
// When the instruction currently held is a load whose rt feeds the incoming
// instruction, one NOP bubble is issued instead and fetch is back-pressured.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset (all state cleared while 0)
//   bus    - id_decode_latch_if.slave:
//              in_valid/in_ready/npc/instr/flush   (IF/ID side)
//              out_valid/out_ready/npc_out/opcode_out/rs_out/rt_out/rd_out/
//              shamt_out/funct_out/imm_out/bubble_cnt (ID/EX side)
//
// Parameters:
//   DATA_W    - width of npc, instr, npc_out, imm_out (>= 16)
//   LW_OPCODE - opcode treated as a load for hazard detection
//   CNT_W     - width of the saturating bubble counter
//
// Optional feature (macro BRANCH_TARGET_EN): adds bus.branch_target, the
// registered value npc + (sign-extended imm << 2), wrapping modulo 2^DATA_W,
// zeroed on reset, bubble and flush.
// ---------------------------------------------------------------------------
module id_decode_latch #(
    parameter int          DATA_W    = 32,
    parameter logic [5:0]  LW_OPCODE = 6'h23,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    id_decode_latch_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BUBBLE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Registered state and outputs
    // -----------------------------------------------------------------------
    state_t            state_reg;
    logic              out_valid_reg;
    logic [DATA_W-1:0] npc_reg;
    logic [5:0]        opcode_reg;
    logic [4:0]        rs_reg;
    logic [4:0]        rt_reg;
    logic [4:0]        rd_reg;
    logic [4:0]        shamt_reg;
    logic [5:0]        funct_reg;
    logic [DATA_W-1:0] imm_reg;
    logic [CNT_W-1:0]  cnt_reg;
`ifdef BRANCH_TARGET_EN
    logic [DATA_W-1:0] target_reg;
    logic [DATA_W-1:0] target_next;
`endif

    // -----------------------------------------------------------------------
    // Field split of the incoming IF/ID instruction
    // -----------------------------------------------------------------------
    logic [5:0]        in_opcode;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] imm_ext;

    assign in_opcode = bus.instr[31:26];
    assign in_rs     = bus.instr[25:21];
    assign in_rt     = bus.instr[20:16];
    assign in_rd     = bus.instr[15:11];
    assign in_shamt  = bus.instr[10:6];
    assign in_funct  = bus.instr[5:0];

    // Sign extension: low half passes through, every upper bit copies bit 15.
    assign imm_ext[15:0] = bus.instr[15:0];
    generate
        for (genvar gi = 16; gi < DATA_W; gi++) begin : g_sext
            assign imm_ext[gi] = bus.instr[15];
        end
    endgenerate

`ifdef BRANCH_TARGET_EN
    // Plain DATA_W-bit add: carries out of the top bit are dropped (wraps).
    assign target_next = bus.npc + (imm_ext << 2);
`endif

    // -----------------------------------------------------------------------
    // Handshake and load-use hazard
    // -----------------------------------------------------------------------
    logic rt_is_source;   // incoming instruction reads its rt field
    logic hz;             // held load feeds the incoming instruction
    logic adv;            // output register may take a new value
    logic in_ready_int;
    logic accept;
    logic bubble;
    logic cnt_full;

    // R-type, beq, bne and sw read rt as a source; other formats write it.
    assign rt_is_source = (in_opcode == 6'h00) || (in_opcode == 6'h04) ||
                          (in_opcode == 6'h05) || (in_opcode == 6'h2B);

    // Only a real held instruction can be a load; a held NOP never is.
    assign hz = (state_reg == ST_HOLD) && out_valid_reg &&
                (opcode_reg == LW_OPCODE) && (rt_reg != 5'd0) &&
                ((rt_reg == in_rs) || ((rt_reg == in_rt) && rt_is_source));

    assign adv          = !out_valid_reg || bus.out_ready;
    // Deliberately independent of in_valid so fetch can rely on it.
    assign in_ready_int = adv && !hz && !bus.flush;
    assign accept       = bus.in_valid && in_ready_int;
    assign bubble       = bus.in_valid && adv && hz && !bus.flush;
    assign cnt_full     = &cnt_reg;

    // -----------------------------------------------------------------------
    // State machine with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
            npc_reg       <= '0;
            opcode_reg    <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            rd_reg        <= '0;
            shamt_reg     <= '0;
            funct_reg     <= '0;
            imm_reg       <= '0;
            cnt_reg       <= '0;
`ifdef BRANCH_TARGET_EN
            target_reg    <= '0;
`endif
        end else if (bus.flush) begin
            // Squash wins even when the consumer is stalled.
            state_reg     <= ST_EMPTY;
            out_valid_reg <= 1'b0;
            npc_reg       <= '0;
            opcode_reg    <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            rd_reg        <= '0;
            shamt_reg     <= '0;
            funct_reg     <= '0;
            imm_reg       <= '0;
`ifdef BRANCH_TARGET_EN
            target_reg    <= '0;
`endif
        end else if (adv) begin
            if (accept) begin
                state_reg     <= ST_HOLD;
                out_valid_reg <= 1'b1;
                npc_reg       <= bus.npc;
                opcode_reg    <= in_opcode;
                rs_reg        <= in_rs;
                rt_reg        <= in_rt;
                rd_reg        <= in_rd;
                shamt_reg     <= in_shamt;
                funct_reg     <= in_funct;
                imm_reg       <= imm_ext;
`ifdef BRANCH_TARGET_EN
                target_reg    <= target_next;
`endif
            end else if (bubble) begin
                // All-zero word is sll $0,$0,0: a NOP that is not a load, so
                // the stalled instruction is accepted on the next advance.
                state_reg     <= ST_BUBBLE;
                out_valid_reg <= 1'b1;
                npc_reg       <= '0;
                opcode_reg    <= '0;
                rs_reg        <= '0;
                rt_reg        <= '0;
                rd_reg        <= '0;
                shamt_reg     <= '0;
                funct_reg     <= '0;
                imm_reg       <= '0;
`ifdef BRANCH_TARGET_EN
                target_reg    <= '0;
`endif
                if (!cnt_full) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                // Drained with nothing new: fields keep their stale values.
                state_reg     <= ST_EMPTY;
                out_valid_reg <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign bus.in_ready   = in_ready_int;
    assign bus.out_valid  = out_valid_reg;
    assign bus.npc_out    = npc_reg;
    assign bus.opcode_out = opcode_reg;
    assign bus.rs_out     = rs_reg;
    assign bus.rt_out     = rt_reg;
    assign bus.rd_out     = rd_reg;
    assign bus.shamt_out  = shamt_reg;
    assign bus.funct_out  = funct_reg;
    assign bus.imm_out    = imm_reg;
    assign bus.bubble_cnt = cnt_reg;
`ifdef BRANCH_TARGET_EN
    assign bus.branch_target = target_reg;
`endif

endmodule

// File: tb/tb_id_decode_latch.sv
// ---------------------------------------------------------------------------
// tb_id_decode_latch
//
// Directed stimulus against id_decode_latch. A word-level model tracks which
// instruction word (or NOP) the ID/EX register must hold; a negedge process
// decodes that word with plain shifts/masks and compares every output each
// cycle. Literal expectations from hand decoding pin the model.
// CNT_W is reduced to 3 so counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_id_decode_latch;

    localparam int DATA_W  = 32;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    int n_checks = 0;
    int n_errors = 0;

    id_decode_latch_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    id_decode_latch #(
        .DATA_W    (DATA_W),
        .LW_OPCODE (6'h23),
        .CNT_W     (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: the raw word held at ID/EX (0 for a NOP), its npc, the count
    // ------------------------------------------------------------------
    logic              m_valid;
    logic [31:0]       m_word;
    logic [31:0]       m_npc;
    int                m_cnt;

    function automatic bit load_use(input logic [31:0] held, input logic [31:0] nxt);
        logic [4:0] lrt;
        logic [5:0] nop;
        lrt = held[20:16];
        nop = nxt[31:26];
        return (held[31:26] == 6'h23) && (lrt != 5'd0) &&
               ((lrt == nxt[25:21]) ||
                ((lrt == nxt[20:16]) &&
                 (nop == 6'h00 || nop == 6'h04 || nop == 6'h05 || nop == 6'h2B)));
    endfunction

    function automatic bit exp_ready();
        bit room;
        bit stall;
        room  = !m_valid || bus.out_ready;
        stall = m_valid && load_use(m_word, bus.instr);
        return room && !stall && !bus.flush;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_word  <= '0;
            m_npc   <= '0;
            m_cnt   <= 0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            m_word  <= '0;
            m_npc   <= '0;
        end else if (!m_valid || bus.out_ready) begin
            if (bus.in_valid && !(m_valid && load_use(m_word, bus.instr))) begin
                m_valid <= 1'b1;
                m_word  <= bus.instr;
                m_npc   <= bus.npc;
            end else if (bus.in_valid) begin
                m_valid <= 1'b1;
                m_word  <= '0;
                m_npc   <= '0;
                if (m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare on the falling edge
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [31:0] ximm;
        if (!reset) begin
            check("rst_out_valid", bus.out_valid, 0);
            check("rst_bubble_cnt", bus.bubble_cnt, 0);
            check("rst_npc_out", bus.npc_out, 0);
        end else begin
            check("out_valid", bus.out_valid, m_valid);
            check("bubble_cnt", bus.bubble_cnt, m_cnt);
            check("in_ready", bus.in_ready, exp_ready());
            if (m_valid) begin
                ximm = (m_word & 32'h0000FFFF);
                if (m_word & 32'h00008000) ximm = ximm | 32'hFFFF0000;
                check("npc_out", bus.npc_out, m_npc);
                check("opcode_out", bus.opcode_out, (m_word >> 26) & 32'h3F);
                check("rs_out", bus.rs_out, (m_word >> 21) & 32'h1F);
                check("rt_out", bus.rt_out, (m_word >> 16) & 32'h1F);
                check("rd_out", bus.rd_out, (m_word >> 11) & 32'h1F);
                check("shamt_out", bus.shamt_out, (m_word >> 6) & 32'h1F);
                check("funct_out", bus.funct_out, m_word & 32'h3F);
                check("imm_out", bus.imm_out, ximm);
`ifdef BRANCH_TARGET_EN
                check("branch_target", bus.branch_target, 32'(m_npc + ximm * 4));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] i, input logic [31:0] n);
        bus.in_valid = 1'b1;
        bus.instr    = i;
        bus.npc      = n;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.npc       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b0;

        // Reset held while an add is presented, then released
        present(32'h012A4020, 32'h100);
        repeat (2) @(posedge clk);
        #1;
        check("lit_rst_valid", bus.out_valid, 0);
        check("lit_rst_imm", bus.imm_out, 0);
        reset = 1'b1;
        tick();
        check("lit_add_valid", bus.out_valid, 1);
        check("lit_add_rs", bus.rs_out, 9);
        check("lit_add_rt", bus.rt_out, 10);
        check("lit_add_rd", bus.rd_out, 8);
        check("lit_add_funct", bus.funct_out, 6'h20);
        bus.in_valid = 1'b0;
        tick();

        // lw $t0,4($s0) then dependent add: one bubble
        present(32'h8E080004, 32'h200);
        tick();
        present(32'h010A4820, 32'h204);
        #1;
        check("lit_lu_in_ready", bus.in_ready, 0);
        tick();
        check("lit_nop_valid", bus.out_valid, 1);
        check("lit_nop_opcode", bus.opcode_out, 0);
        check("lit_nop_npc", bus.npc_out, 0);
        check("lit_bubble_cnt1", bus.bubble_cnt, 1);
        check("lit_nop_in_ready", bus.in_ready, 1);
        tick();
        check("lit_dep_rd", bus.rd_out, 9);
        check("lit_dep_npc", bus.npc_out, 32'h204);
        bus.in_valid = 1'b0;
        tick();

        // lw with rt=0, then add using $0: no bubble
        present(32'h8E000004, 32'h300);
        tick();
        present(32'h00004020, 32'h304);
        #1;
        check("lit_rt0_in_ready", bus.in_ready, 1);
        tick();
        check("lit_rt0_npc", bus.npc_out, 32'h304);
        check("lit_rt0_cnt", bus.bubble_cnt, 1);
        bus.in_valid = 1'b0;
        tick();

        // Stall 3 cycles while holding addi with imm -1
        present(32'h2108FFFF, 32'h400);
        tick();
        present(32'h012A4020, 32'h404);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("lit_stall_in_ready", bus.in_ready, 0);
            check("lit_stall_imm", bus.imm_out, 32'hFFFFFFFF);
            check("lit_stall_npc", bus.npc_out, 32'h400);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("lit_unstall_npc", bus.npc_out, 32'h404);
        bus.in_valid = 1'b0;
        tick();

        // Flush while holding lw and presenting a dependent add
        present(32'h8E080004, 32'h500);
        tick();
        present(32'h010A4820, 32'h504);
        bus.flush = 1'b1;
        tick();
        check("lit_flush_valid", bus.out_valid, 0);
        check("lit_flush_cnt", bus.bubble_cnt, 1);
        check("lit_flush_npc", bus.npc_out, 0);
        bus.flush = 1'b0;
        tick();
        check("lit_after_flush_npc", bus.npc_out, 32'h504);

        // Flush while the consumer is stalled still clears
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b1;
        tick();
        check("lit_flush_stall_valid", bus.out_valid, 0);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        tick();

        // Reset in the middle of a bubble
        present(32'h8E080004, 32'h600);
        tick();
        present(32'h010A4820, 32'h604);
        tick();
        check("lit_pre_rst_cnt", bus.bubble_cnt, 2);
        reset = 1'b0;
        #1;
        check("lit_rst_mid_valid", bus.out_valid, 0);
        check("lit_rst_mid_cnt", bus.bubble_cnt, 0);
        tick();
        reset = 1'b1;
        tick();
        check("lit_represent_npc", bus.npc_out, 32'h604);

        // Nine load-use pairs: counter saturates at all-ones
        for (int k = 0; k < 9; k++) begin
            present(32'h8E080004, 32'h700);
            tick();
            present(32'h010A4820, 32'h704);
            tick();
            tick();
        end
        check("lit_cnt_sat", bus.bubble_cnt, CNT_MAX);

`ifdef BRANCH_TARGET_EN
        // beq with wrapping target
        present(32'h10000002, 32'hFFFFFFFC);
        tick();
        check("lit_branch_wrap", bus.branch_target, 32'h00000004);
`endif

        bus.in_valid = 1'b0;
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
